// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: flag struct, opcode map and FSM states.
package alu_pkg;

    // Carry and zero flags, registered together with the result.
    typedef struct packed {
        logic C;
        logic Z;
    } ALUFlagsStruct;

    // Opcode map, unchanged from the combinational ALU. Codes 4'hA..4'hF are illegal.
    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_NOT = 4'd5,
        OP_SUB = 4'd6,
        OP_XOR = 4'd7,
        OP_SL  = 4'd8,
        OP_SR  = 4'd9
    } alu_op_e;

    // IDLE accepts requests; SHIFT runs the iterative shifter.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_shifter_iter.sv
// Iterative one-bit-per-clock shifter: shift register, fill/direction latch and down-counter.
// dout/cout present the value and the bit shifted out by the step the next edge performs,
// so the owner can capture the final result on the edge that performs the last shift.
module alu_shifter_iter #(
    parameter int n = 4,
    localparam int SHW = $clog2(n + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           dir,        // 0 = left, 1 = right
    input  logic           fill,
    input  logic [n-1:0]   din,
    input  logic [SHW-1:0] amount,
    output logic           last_step,
    output logic [n-1:0]   dout,
    output logic           cout
);

    logic [n-1:0]   sreg_q;
    logic [SHW-1:0] cnt_q;
    logic           dir_q;
    logic           fill_q;

    // One-step shift of the current register contents.
    always_comb begin
        dout = sreg_q;
        cout = 1'b0;
        if (dir_q) begin
            dout = {fill_q, sreg_q[n-1:1]};
            cout = sreg_q[0];
        end else begin
            dout = {sreg_q[n-2:0], fill_q};
            cout = sreg_q[n-1];
        end
    end

    assign last_step = (cnt_q == SHW'(1));

    // Load operands on request, then shift once per edge until the counter empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else if (load) begin
            sreg_q <= din;
            cnt_q  <= amount;
            dir_q  <= dir;
            fill_q <= fill;
        end else if (cnt_q != '0) begin
            sreg_q <= dout;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with start/busy/done handshake and an iterative shifter.
// Handshake: ALUStart is sampled only in IDLE (ignored while ALUBusy=1, never queued);
// ALUDone is a one-cycle pulse, and ALUResult/ALUFlags/ALUIllegal are valid from that
// cycle and held until the next completion.
module alu_seq
    import alu_pkg::*;
#(
    parameter int n = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ALUStart,
    input  logic [n-1:0]  ALUA,
    input  logic [n-1:0]  ALUB,
    input  logic          ALUFlagIn,
    input  logic [3:0]    ALUControl,
    output logic          ALUBusy,
    output logic          ALUDone,
    output logic [n-1:0]  ALUResult,
    output ALUFlagsStruct ALUFlags,
    output logic          ALUIllegal
);

    localparam int SHW = $clog2(n + 1);
    localparam logic [n-1:0]   N_LIM  = n[n-1:0];
    localparam logic [SHW-1:0] SH_MAX = SHW'(n);

    alu_state_e     state_q;
    logic [n-1:0]   result_q;
    ALUFlagsStruct  flags_q;
    logic           done_q;
    logic           illegal_q;

    logic           is_shift;
    logic           is_illegal;
    logic [SHW-1:0] shamt;
    logic           sh_load;
    logic           sh_last;
    logic [n-1:0]   sh_dout;
    logic           sh_cout;

    logic [n-1:0]   alu_r;
    logic           alu_c;
    logic [n-1:0]   op_x;
    logic [n:0]     sum;

    assign is_shift   = (ALUControl == OP_SL) || (ALUControl == OP_SR);
    assign is_illegal = (ALUControl > OP_SR);
    // Shift amount saturates at the datapath width.
    assign shamt      = (ALUB >= N_LIM) ? SH_MAX : ALUB[SHW-1:0];
    assign sh_load    = (state_q == S_IDLE) && ALUStart && is_shift && (shamt != '0);

    // Single-cycle datapath; shifts and illegal opcodes fall through to zero here.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        sum   = '0;
        op_x  = ALUFlagIn ? ALUB : ALUA;
        case (ALUControl)
            OP_AND: alu_r = ALUA & ALUB;
            OP_OR:  alu_r = ALUA | ALUB;
            OP_XOR: alu_r = ALUA ^ ALUB;
            OP_ADD: begin
                sum   = {1'b0, ALUA} + {1'b0, ALUB} + {{n{1'b0}}, ALUFlagIn};
                alu_r = sum[n-1:0];
                alu_c = sum[n];
            end
            OP_SUB: begin
                sum   = {1'b0, ALUA} + {1'b0, ~ALUB} + {{n{1'b0}}, ALUFlagIn};
                alu_r = sum[n-1:0];
                alu_c = sum[n];
            end
            OP_INC: alu_r = op_x + 1'b1;
            OP_DEC: alu_r = op_x - 1'b1;
            OP_NOT: alu_r = ~op_x;
            default: alu_r = '0;
        endcase
    end

    alu_shifter_iter #(.n(n)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .dir       (ALUControl == OP_SR),
        .fill      (ALUFlagIn),
        .din       (ALUA),
        .amount    (shamt),
        .last_step (sh_last),
        .dout      (sh_dout),
        .cout      (sh_cout)
    );

    // Control FSM and result/flag registers; outputs only change on completion edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ALUStart) begin
                        if (is_shift) begin
                            if (shamt == '0) begin
                                result_q  <= ALUA;
                                flags_q   <= '{C: 1'b0, Z: ~|ALUA};
                                illegal_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                state_q <= S_SHIFT;
                            end
                        end else begin
                            result_q  <= alu_r;
                            flags_q   <= '{C: alu_c, Z: ~|alu_r};
                            illegal_q <= is_illegal;
                            done_q    <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (sh_last) begin
                        result_q  <= sh_dout;
                        flags_q   <= '{C: sh_cout, Z: ~|sh_dout};
                        illegal_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ALUBusy    = (state_q == S_SHIFT);
    assign ALUDone    = done_q;
    assign ALUResult  = result_q;
    assign ALUFlags   = flags_q;
    assign ALUIllegal = illegal_q;

endmodule
